// File: rtl/rtc_apb_master.sv
// APB3 master for the RTC register slave: buffered valid/ready commands, SETUP/ACCESS serialisation, one-cycle responses.
// Optional ACCESS timeout abort is built when RTC_APB_MASTER_TIMEOUT_EN is defined.
module rtc_apb_master #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [7:0]  paddr,
  output logic [31:0] pwdata,
  input  logic        pready,
  input  logic [31:0] prdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshake: a command moves when cmd_valid && cmd_ready on a rising pclk;
  // cmd_ready only depends on FIFO occupancy. Responses have no backpressure.

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 1 + 8 + 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT < 2)) begin : g_bad_params
    $error("rtc_apb_master: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
  end

  state_t        state;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          avail_q;
  logic          push;
  logic          pop;
  logic          done;
  logic          timeout_hit;
  logic [EW-1:0] head;

  assign cmd_ready = (count != CW'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign done      = (state == ACCESS) && (pready || timeout_hit);
  assign pop       = ((state == IDLE) && avail_q) || (done && (count != '0));
  assign busy      = (state != IDLE) || (count != '0);
  assign state_dbg = state;

`ifdef RTC_APB_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);
  logic [TW-1:0] tmo_cnt;
  logic          rsp_err_q;
  assign timeout_hit = (state == ACCESS) && !pready && (tmo_cnt == TW'(TIMEOUT - 1));
  assign rsp_err     = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  // The idle FSM looks at a registered occupancy flag, giving one cycle between
  // a push landing and the FIFO head being issued. Only the FSM pops, so the
  // flag can never claim data that has already left while the FSM is idle.
  always_ff @(posedge pclk) begin
    if (preset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      avail_q <= 1'b0;
    end else begin
      avail_q <= (count != '0);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
`ifdef RTC_APB_MASTER_TIMEOUT_EN
      tmo_cnt   <= '0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (avail_q) begin
            {pwrite, paddr, pwdata} <= head;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
`ifdef RTC_APB_MASTER_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (done) begin
            rsp_valid <= 1'b1;
            rsp_write <= pwrite;
            rsp_rdata <= (pwrite || timeout_hit) ? 32'h0 : prdata;
`ifdef RTC_APB_MASTER_TIMEOUT_EN
            rsp_err_q <= timeout_hit;
`endif
            // Chain straight into the next SETUP so psel never drops between queued commands.
            if (count != '0) begin
              {pwrite, paddr, pwdata} <= head;
              penable <= 1'b0;
              state   <= SETUP;
            end else begin
              psel    <= 1'b0;
              penable <= 1'b0;
              state   <= IDLE;
            end
          end
`ifdef RTC_APB_MASTER_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_apb_master.sv
// Directed bench for rtc_apb_master: reset, single write, wait-state read, FIFO full and drain,
// alternating read/write, mid-transfer reset, and the timeout abort when RTC_APB_MASTER_TIMEOUT_EN is set.
module tb_rtc_apb_master;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [1:0]  state_dbg;

  logic        slave_echo;
  logic [31:0] prdata_drv;

  int checks;
  int failures;
  logic [32:0] exp_q[$];

  // Echo mode lets read data identify which address was being accessed.
  assign prdata = slave_echo ? {24'hC0FFEE, paddr} : prdata_drv;

  rtc_apb_master #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 pclk = ~pclk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic push_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    preset    = 1'b1;
    tick();
    tick();
    preset    = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({psel, penable, pwrite, rsp_valid, rsp_write, rsp_err, busy, cmd_ready} !== 8'b0000_0001) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000001", {psel, penable, pwrite, rsp_valid, rsp_write, rsp_err, busy, cmd_ready}); end
    checks++; if ({paddr, pwdata, rsp_rdata} !== 72'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {paddr, pwdata, rsp_rdata}); end
    checks++; if (state_dbg !== 2'd0) begin
      failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_single_write();
    do_reset();
    pready = 1'b1;
    push_cmd(1'b1, 8'h08, 32'h0000_0017);
    checks++; if ({psel, busy} !== 2'b01) begin
      failures++; $display("FAIL wr_accept psel/busy got=%b exp=01", {psel, busy}); end
    tick();
    checks++; if ({psel, penable} !== 2'b00) begin
      failures++; $display("FAIL wr_latency psel/penable got=%b exp=00", {psel, penable}); end
    tick();
    checks++; if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 8'h08, 32'h17}) begin
      failures++; $display("FAIL wr_setup got=%h exp=%h", {psel, penable, pwrite, paddr, pwdata}, {3'b101, 8'h08, 32'h17}); end
    tick();
    checks++; if ({psel, penable, rsp_valid, paddr, pwdata} !== {3'b110, 8'h08, 32'h17}) begin
      failures++; $display("FAIL wr_access got=%h exp=%h", {psel, penable, rsp_valid, paddr, pwdata}, {3'b110, 8'h08, 32'h17}); end
    tick();
    checks++; if ({rsp_valid, rsp_write, rsp_err, psel, penable, rsp_rdata} !== {5'b11000, 32'h0}) begin
      failures++; $display("FAIL wr_rsp got=%h exp=%h", {rsp_valid, rsp_write, rsp_err, psel, penable, rsp_rdata}, {5'b11000, 32'h0}); end
    tick();
    checks++; if ({rsp_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL wr_after rsp_valid/busy got=%b exp=00", {rsp_valid, busy}); end
  endtask

  task automatic test_read_wait();
    do_reset();
    pready     = 1'b0;
    prdata_drv = 32'hDEAD_BEEF;
    push_cmd(1'b0, 8'h04, 32'h0);
    tick();
    tick();
    checks++; if ({psel, penable, pwrite, paddr} !== {3'b100, 8'h04}) begin
      failures++; $display("FAIL rd_setup got=%h exp=%h", {psel, penable, pwrite, paddr}, {3'b100, 8'h04}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({psel, penable, rsp_valid} !== 3'b110) begin
        failures++; $display("FAIL rd_wait%0d got=%b exp=110", i, {psel, penable, rsp_valid}); end
    end
    tick();
    checks++; if ({psel, penable, rsp_valid} !== 3'b110) begin
      failures++; $display("FAIL rd_access4 got=%b exp=110", {psel, penable, rsp_valid}); end
    pready     = 1'b1;
    prdata_drv = 32'h0000_002A;
    tick();
    checks++; if ({rsp_valid, rsp_write, rsp_err, psel, rsp_rdata} !== {4'b1000, 32'h2A}) begin
      failures++; $display("FAIL rd_rsp got=%h exp=%h", {rsp_valid, rsp_write, rsp_err, psel, rsp_rdata}, {4'b1000, 32'h2A}); end
    prdata_drv = 32'h0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic       wr;
    logic [32:0] e;
    int n;
    int gaps;
    do_reset();
    pready     = 1'b0;
    slave_echo = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr = (i % 2) == 1;
      a  = 8'h20 + 8'(i);
      push_cmd(wr, a, 32'h100 + 32'(i));
      exp_q.push_back({wr, wr ? 32'h0 : {24'hC0FFEE, a}});
    end
    // One command is already in flight, so the fifth push fills the FIFO.
    checks++; if (cmd_ready !== 1'b0) begin
      failures++; $display("FAIL full_ready got=%b exp=0", cmd_ready); end
    push_cmd(1'b1, 8'h77, 32'hBAD0_BAD0);
    checks++; if ({cmd_ready, psel, penable, paddr} !== {3'b011, 8'h20}) begin
      failures++; $display("FAIL full_hold got=%h exp=%h", {cmd_ready, psel, penable, paddr}, {3'b011, 8'h20}); end
    pready = 1'b1;
    n      = 0;
    gaps   = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      tick();
      if (rsp_valid) begin
        checks++; if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_extra_rsp got=%0d exp=5", n + 1); end
        else begin
          e = exp_q.pop_front();
          if ({rsp_write, rsp_rdata} !== e) begin
            failures++; $display("FAIL b2b_rsp%0d got=%h exp=%h", n, {rsp_write, rsp_rdata}, e); end
        end
        checks++; if (cyc != 1 + 2 * n) begin
          failures++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", n, cyc, 1 + 2 * n); end
        n++;
      end
      if (n < 5 && psel !== 1'b1) gaps++;
    end
    checks++; if (n != 5) begin
      failures++; $display("FAIL b2b_count got=%0d exp=5", n); end
    checks++; if (gaps != 0) begin
      failures++; $display("FAIL b2b_psel_gaps got=%0d exp=0", gaps); end
    checks++; if ({busy, cmd_ready} !== 2'b01) begin
      failures++; $display("FAIL b2b_drained got=%b exp=01", {busy, cmd_ready}); end
    slave_echo = 1'b0;
  endtask

  task automatic test_alternate();
    logic [7:0]  sa;
    logic [31:0] sd;
    logic        sw;
    logic        wr;
    logic [32:0] e;
    int s;
    int r;
    int unstable;
    do_reset();
    pready     = 1'b1;
    prdata_drv = 32'h1234_5678;
    s = 0; r = 0; unstable = 0;
    sa = '0; sd = '0; sw = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc < 4) begin
        wr        = (cyc % 2) == 1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = wr ? 8'h00 : 8'hFF;
        cmd_wdata = wr ? 32'hFFFF_FFFF : 32'h0;
        exp_q.push_back({wr, wr ? 32'h0 : 32'h1234_5678});
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      if (psel && !penable) begin
        sa = paddr; sd = pwdata; sw = pwrite;
        wr = (s % 2) == 1;
        checks++; if ({sw, sa} !== {wr, wr ? 8'h00 : 8'hFF} || (wr && sd !== 32'hFFFF_FFFF)) begin
          failures++; $display("FAIL alt_setup%0d got=%h exp_wr=%b", s, {sw, sa, sd}, wr); end
        s++;
      end
      if (psel && penable && ({pwrite, paddr, pwdata} !== {sw, sa, sd})) unstable++;
      if (rsp_valid) begin
        checks++; if (exp_q.size() == 0) begin
          failures++; $display("FAIL alt_extra_rsp got=%0d exp=4", r + 1); end
        else begin
          e = exp_q.pop_front();
          if ({rsp_write, rsp_rdata} !== e) begin
            failures++; $display("FAIL alt_rsp%0d got=%h exp=%h", r, {rsp_write, rsp_rdata}, e); end
        end
        r++;
      end
    end
    checks++; if (s != 4 || r != 4) begin
      failures++; $display("FAIL alt_counts got=%0d/%0d exp=4/4", s, r); end
    checks++; if (unstable != 0) begin
      failures++; $display("FAIL alt_stability got=%0d exp=0", unstable); end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    pready = 1'b0;
    push_cmd(1'b1, 8'h30, 32'h30);
    push_cmd(1'b1, 8'h31, 32'h31);
    push_cmd(1'b0, 8'h32, 32'h0);
    tick();
    checks++; if ({psel, penable, busy, cmd_ready} !== 4'b1111) begin
      failures++; $display("FAIL rstmid_pre got=%b exp=1111", {psel, penable, busy, cmd_ready}); end
    preset = 1'b1;
    pready = 1'b1;
    tick();
    preset = 1'b0;
    checks++; if ({psel, penable, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
      failures++; $display("FAIL rstmid_post got=%b exp=00001", {psel, penable, rsp_valid, busy, cmd_ready}); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid || psel) bad++;
    end
    checks++; if (bad != 0) begin
      failures++; $display("FAIL rstmid_quiet got=%0d exp=0", bad); end
  endtask

`ifdef RTC_APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int acc;
    int cnt;
    logic got;
    do_reset();
    pready     = 1'b0;
    prdata_drv = 32'h5555_AAAA;
    push_cmd(1'b1, 8'h40, 32'h77);
    push_cmd(1'b0, 8'h44, 32'h0);
    tick();
    checks++; if ({psel, penable, paddr} !== {2'b10, 8'h40}) begin
      failures++; $display("FAIL tmo_setup got=%h exp=%h", {psel, penable, paddr}, {2'b10, 8'h40}); end
    acc = 0; cnt = 0; got = 1'b0;
    while (!got && cnt < 40) begin
      tick();
      cnt++;
      if (rsp_valid) got = 1'b1;
      else if (penable) acc++;
    end
    checks++; if (got !== 1'b1 || acc != 16) begin
      failures++; $display("FAIL tmo_abort got=%b/%0d exp=1/16", got, acc); end
    checks++; if ({rsp_write, rsp_err, penable, paddr, rsp_rdata} !== {3'b110, 8'h44, 32'h0}) begin
      failures++; $display("FAIL tmo_rsp got=%h exp=%h", {rsp_write, rsp_err, penable, paddr, rsp_rdata}, {3'b110, 8'h44, 32'h0}); end
    pready = 1'b1;
    tick();
    tick();
    checks++; if ({rsp_valid, rsp_write, rsp_err, psel, rsp_rdata} !== {4'b1000, 32'h5555_AAAA}) begin
      failures++; $display("FAIL tmo_next got=%h exp=%h", {rsp_valid, rsp_write, rsp_err, psel, rsp_rdata}, {4'b1000, 32'h5555_AAAA}); end
  endtask

  task automatic test_timeout_edge();
    do_reset();
    pready = 1'b0;
    push_cmd(1'b1, 8'h48, 32'h48);
    tick();
    tick();
    for (int i = 0; i < 16; i++) tick();
    checks++; if ({penable, rsp_valid} !== 2'b10) begin
      failures++; $display("FAIL tmo_edge_wait got=%b exp=10", {penable, rsp_valid}); end
    pready = 1'b1;
    tick();
    checks++; if ({rsp_valid, rsp_err, rsp_write} !== 3'b101) begin
      failures++; $display("FAIL tmo_edge_rsp got=%b exp=101", {rsp_valid, rsp_err, rsp_write}); end
  endtask
`endif

  initial begin
    checks     = 0;
    failures   = 0;
    preset     = 1'b1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    pready     = 1'b1;
    slave_echo = 1'b0;
    prdata_drv = '0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_back_to_back();
    test_alternate();
    test_reset_mid();
`ifdef RTC_APB_MASTER_TIMEOUT_EN
    test_timeout();
    test_timeout_edge();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
